// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates the pipeline (port 0) and the DMA/debug loader (port 1)
// onto a single-port word memory and sequences each granted access.
// Sub-word stores become a read-modify-write; loads are extended to RV32I semantics.
module dmem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_we,
    input  logic [31:0]   req_addr0,
    input  logic [31:0]   req_addr1,
    input  logic [2:0]    req_funct3_0,
    input  logic [2:0]    req_funct3_1,
    input  logic [31:0]   req_wdata0,
    input  logic [31:0]   req_wdata1,
    output logic [1:0]    resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_RMW_WR  = 2'd2
    } state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    // Insert a byte (funct3 SB) or halfword (funct3 SH) into a word at the given lane
    function automatic logic [31:0] merge_sub(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] lane, input logic half);
        logic [31:0] res;
        res = word;
        if (half) begin
            if (lane[1]) begin
                res[31:16] = data;
            end else begin
                res[15:0] = data;
            end
        end else begin
            case (lane)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                default: res[31:24] = data[7:0];
            endcase
        end
        return res;
    endfunction

    // Select and extend the loaded byte/half/word according to funct3
    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b100:  res = {24'h0, byte_v};
            3'b101:  res = {16'h0, half_v};
            default: res = word;   // LW; other encodings never reach a load
        endcase
        return res;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic            last_grant_r;
    logic            port_r;
    logic [1:0]      lane_r;
    logic [2:0]      funct3_r;
    logic [15:0]     wdata_r;
    logic [AW-1:0]   waddr_r;
    logic [1:0]      resp_valid_r;
    logic [31:0]     resp_rdata_r;
    logic            resp_err_r;

    logic            grant_s;
    logic            accept_s;
    logic            err_s;
    logic            sw_s;
    logic            sel_we_s;
    logic [31:0]     sel_addr_s;
    logic [31:0]     sel_wdata_s;
    logic [2:0]      sel_funct3_s;
    logic            range_err_s;
    logic            align_err_s;
    logic            funct3_err_s;

    // Round-robin grant on ties and decode of the granted request's error conditions
    always_comb begin
        grant_s      = 1'b0;
        sel_we_s     = 1'b0;
        sel_addr_s   = 32'h0;
        sel_wdata_s  = 32'h0;
        sel_funct3_s = 3'b000;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
        if (grant_s) begin
            sel_we_s     = req_we[1];
            sel_addr_s   = req_addr1;
            sel_wdata_s  = req_wdata1;
            sel_funct3_s = req_funct3_1;
        end else begin
            sel_we_s     = req_we[0];
            sel_addr_s   = req_addr0;
            sel_wdata_s  = req_wdata0;
            sel_funct3_s = req_funct3_0;
        end
        range_err_s = (sel_addr_s[31:2] >= DEPTH_W);
        align_err_s = ((sel_funct3_s[1:0] == 2'b01) && sel_addr_s[0]) ||
                      ((sel_funct3_s[1:0] == 2'b10) && (sel_addr_s[1:0] != 2'b00));
        if (sel_we_s) begin
            funct3_err_s = (sel_funct3_s > 3'b010);
        end else begin
            funct3_err_s = (sel_funct3_s == 3'b011) || (sel_funct3_s[2:1] == 2'b11);
        end
        err_s = range_err_s || align_err_s || funct3_err_s;
        sw_s  = sel_we_s && (sel_funct3_s == 3'b010);
    end

    // Next-state logic, handshake and memory command generation
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        req_ready    = 2'b00;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        case (state_r)
            ST_IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    accept_s  = 1'b1;
                    req_ready = grant_s ? 2'b10 : 2'b01;
                    if (err_s) begin
                        next_state_s = ST_IDLE;
                    end else if (sw_s) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = sel_addr_s[AW+1:2];
                        mem_wdata = sel_wdata_s;
                    end else if (sel_we_s) begin
                        mem_en       = 1'b1;
                        mem_addr     = sel_addr_s[AW+1:2];
                        next_state_s = ST_RMW_WR;
                    end else begin
                        mem_en       = 1'b1;
                        mem_addr     = sel_addr_s[AW+1:2];
                        next_state_s = ST_LD_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LD_WAIT: begin
                next_state_s = ST_IDLE;
            end
            ST_RMW_WR: begin
                next_state_s = ST_IDLE;
                if (!rst) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = waddr_r;
                    mem_wdata = merge_sub(mem_rdata, wdata_r, lane_r, funct3_r[0]);
                end else begin
                    mem_en = 1'b0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, grant history and fields latched at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            port_r       <= 1'b0;
            lane_r       <= 2'b00;
            funct3_r     <= 3'b000;
            wdata_r      <= 16'h0;
            waddr_r      <= '0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                last_grant_r <= grant_s;
                port_r       <= grant_s;
                lane_r       <= sel_addr_s[1:0];
                funct3_r     <= sel_funct3_s;
                wdata_r      <= sel_wdata_s[15:0];
                waddr_r      <= sel_addr_s[AW+1:2];
            end
        end
    end

    // Registered one-cycle response pulse; data and error hold until the next response
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 2'b00;
            resp_rdata_r <= 32'h0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= 2'b00;
            if (accept_s && (err_s || sw_s)) begin
                resp_valid_r <= grant_s ? 2'b10 : 2'b01;
                resp_err_r   <= err_s;
                resp_rdata_r <= 32'h0;
            end else if (state_r == ST_LD_WAIT) begin
                resp_valid_r <= port_r ? 2'b10 : 2'b01;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= format_load(mem_rdata, funct3_r, lane_r);
            end else if (state_r == ST_RMW_WR) begin
                resp_valid_r <= port_r ? 2'b10 : 2'b01;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'h0;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word memory model, transaction-level reference model with a
// per-cycle compare process, and directed vectors with hand-computed results.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst;
    logic          v0, v1, we0, we1;
    logic [1:0]    req_valid, req_ready, req_we, resp_valid;
    logic [31:0]   req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [2:0]    req_funct3_0, req_funct3_1;
    logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
    logic          resp_err, mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;

    assign req_valid = {v1, v0};
    assign req_we    = {we1, we0};

    int checks = 0;
    int errors = 0;
    int pcyc   = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Single-port synchronous memory array
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, pcyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] rdata;
        logic        wr;
        int          widx;
        logic [31:0] wval;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          free_cycle = 0;
    int          rmw_cycle  = -1;
    int          rmw_widx   = 0;
    logic        last_g     = 1'b1;
    logic [31:0] hold_rdata = 32'h0;
    logic        hold_err   = 1'b0;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f, input logic [1:0] lane);
        logic [31:0] v;
        case (f)
            3'b000, 3'b100: begin
                v = (w >> (8 * int'(lane))) & 32'hFF;
                if (f == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * int'(lane[1]))) & 32'hFFFF;
                if (f == 3'b001 && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f, input logic [1:0] lane);
        logic [31:0] mask;
        mask = (f[1:0] == 2'b00) ? 32'hFF : 32'hFFFF;
        mask = mask << (8 * int'(lane));
        return (old & ~mask) | ((wd << (8 * int'(lane))) & mask);
    endfunction

    initial begin : model_cmp
        exp_t        e;
        logic [1:0]  rv_exp, rdy_exp;
        logic        en_exp, we_exp, busy_exp, w, bad;
        int          p, widx, lat, size;
        logic [31:0] a, wd;
        logic [2:0]  f;
        logic [AW-1:0] addr_exp;
        forever begin
            @(negedge clk);
            rv_exp = 2'b00;
            if (q.size() > 0 && q[0].due == pcyc) begin
                e = q.pop_front();
                rv_exp[e.port] = 1'b1;
                hold_rdata = e.rdata;
                hold_err   = e.err;
                if (e.wr) ref_mem[e.widx] = e.wval;
            end
            chk("resp_valid", resp_valid, rv_exp);
            chk("resp_rdata", resp_rdata, hold_rdata);
            chk("resp_err", resp_err, hold_err);
            busy_exp = (pcyc < free_cycle);
            rdy_exp = 2'b00; en_exp = 1'b0; we_exp = 1'b0; addr_exp = '0;
            if (rst) begin
                q.delete();
                free_cycle = 0;
                rmw_cycle  = -1;
                last_g     = 1'b1;
            end else begin
                if (pcyc == rmw_cycle) begin
                    en_exp = 1'b1; we_exp = 1'b1; addr_exp = AW'(rmw_widx);
                end
                if (pcyc >= free_cycle && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) p = last_g ? 0 : 1;
                    else                    p = req_valid[1] ? 1 : 0;
                    last_g = p[0];
                    rdy_exp[p] = 1'b1;
                    a  = p ? req_addr1 : req_addr0;
                    f  = p ? req_funct3_1 : req_funct3_0;
                    wd = p ? req_wdata1 : req_wdata0;
                    w  = req_we[p];
                    widx = int'(a[31:2]);
                    size = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
                    bad = w ? !(f inside {3'b000, 3'b001, 3'b010}) : (f inside {3'b011, 3'b110, 3'b111});
                    bad = bad || (widx >= DEPTH) || ((int'(a[1:0]) % size) != 0);
                    e.port = p; e.err = bad; e.rdata = 32'h0; e.wr = 1'b0; e.widx = widx; e.wval = 32'h0;
                    if (bad) begin
                        lat = 1;
                    end else if (w && f == 3'b010) begin
                        lat = 1; e.wr = 1'b1; e.wval = wd;
                        en_exp = 1'b1; we_exp = 1'b1; addr_exp = AW'(widx);
                    end else if (w) begin
                        lat = 2; e.wr = 1'b1; e.wval = model_merge(ref_mem[widx], wd, f, a[1:0]);
                        en_exp = 1'b1; addr_exp = AW'(widx);
                        rmw_cycle = pcyc + 1; rmw_widx = widx;
                    end else begin
                        lat = 2; e.rdata = model_load(ref_mem[widx], f, a[1:0]);
                        en_exp = 1'b1; addr_exp = AW'(widx);
                    end
                    e.due = pcyc + lat;
                    free_cycle = pcyc + lat;
                    q.push_back(e);
                end
            end
            chk("req_ready", req_ready, rdy_exp);
            chk("mem_en", mem_en, en_exp);
            chk("mem_we", mem_we, we_exp);
            chk("busy", busy, busy_exp);
            if (en_exp) chk("mem_addr", mem_addr, addr_exp);
            if (rst) begin
                hold_rdata = 32'h0;
                hold_err   = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output int acc);
        logic got;
        int   n;
        if (p == 0) begin v0 = 1'b1; we0 = we; req_addr0 = a; req_funct3_0 = f3; req_wdata0 = wd; end
        else        begin v1 = 1'b1; we1 = we; req_addr1 = a; req_funct3_1 = f3; req_wdata1 = wd; end
        got = 1'b0; n = 0; acc = -1;
        while (!got && n < 40) begin
            @(negedge clk);
            got = req_ready[p];
            if (got) acc = pcyc;
            n++;
            @(posedge clk);
            #1;
        end
        if (p == 0) v0 = 1'b0;
        else        v1 = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout port=%0d addr=%h actual=no_ready required=ready", p, a);
        end
    endtask

    task automatic wait_resp(input int p, output logic [31:0] d, output logic e, output int n);
        logic got;
        got = 1'b0; n = 0; d = 32'h0; e = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (resp_valid[p]) begin got = 1'b1; d = resp_rdata; e = resp_err; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout port=%0d actual=no_resp required=resp", p);
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] le_addr [4] = '{32'h4, 32'h6, 32'h6, 32'h4};
    logic [2:0]  le_f3   [4] = '{3'b000, 3'b001, 3'b101, 3'b010};
    logic [31:0] le_exp  [4] = '{32'hFFFFFFFF, 32'hFFFF8001, 32'h00008001, 32'h8001F0FF};
    logic        er_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] er_addr [4] = '{32'h3, 32'h1002, 32'h0, 32'h4};
    logic [2:0]  er_f3   [4] = '{3'b001, 3'b010, 3'b011, 3'b011};
    int          final_words [13] = '{1, 2, 3, 5, 6, 8, 9, 10, 11, 16, 17, 18, 19};
    int          a0 [4];
    int          a1 [4];

    initial begin : global_timeout
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        logic [31:0] d;
        logic        e;
        int          n, c0, c1, acc;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        req_addr0 = 32'h0; req_addr1 = 32'h0; req_funct3_0 = 3'b000; req_funct3_1 = 3'b000;
        req_wdata0 = 32'h0; req_wdata1 = 32'h0;

        // reset values
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 32'h0);
        chk("rst_mem_en", mem_en, 32'h0);
        chk("rst_busy", busy, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // preload, then tie between two loads: port 0 first, port 1 two cycles later
        drive(0, 1'b1, 32'h14, 3'b010, 32'h12345678, acc);
        drive(1, 1'b1, 32'h18, 3'b010, 32'h9ABCDEF0, acc);
        fork
            drive(0, 1'b0, 32'h14, 3'b010, 32'h0, c0);
            drive(1, 1'b0, 32'h18, 3'b010, 32'h0, c1);
        join
        chk("tie_order", 32'(c1 - c0), 32'd2);
        wait_resp(1, d, e, n);
        chk("tie_p1_rdata", d, 32'h9ABCDEF0);

        // byte store merge
        drive(0, 1'b1, 32'hC, 3'b010, 32'hAABBCCDD, acc);
        wait_resp(0, d, e, n);
        chk("sw_latency", n, 32'd1);
        drive(0, 1'b1, 32'hD, 3'b000, 32'h11, acc);
        wait_resp(0, d, e, n);
        chk("sb_latency", n, 32'd2);
        chk("sb_word", mem[3], 32'hAABB11DD);
        drive(0, 1'b0, 32'hD, 3'b100, 32'h0, acc);
        wait_resp(0, d, e, n);
        chk("lbu_rdata", d, 32'h00000011);

        // load extension
        drive(1, 1'b1, 32'h4, 3'b010, 32'h8001F0FF, acc);
        wait_resp(1, d, e, n);
        for (int i = 0; i < 4; i++) begin
            drive(i % 2, 1'b0, le_addr[i], le_f3[i], 32'h0, acc);
            wait_resp(i % 2, d, e, n);
            chk("load_ext", d, le_exp[i]);
            chk("load_latency", n, 32'd2);
        end

        // halfword store into upper lane
        drive(1, 1'b1, 32'hE, 3'b001, 32'hFFFF5566, acc);
        wait_resp(1, d, e, n);
        chk("sh_word", mem[3], 32'h556611DD);

        // rejected accesses
        for (int i = 0; i < 4; i++) begin
            drive(0, er_we[i], er_addr[i], er_f3[i], 32'hDEADBEEF, acc);
            wait_resp(0, d, e, n);
            chk("err_flag", e, 32'd1);
            chk("err_rdata", d, 32'h0);
            chk("err_latency", n, 32'd1);
        end
        chk("err_mem1", mem[1], 32'h8001F0FF);
        chk("err_mem3", mem[3], 32'h556611DD);

        // round-robin stream of word stores after a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            begin : rr_p0
                for (int i = 0; i < 4; i++) drive(0, 1'b1, 32'h20 + 32'(4 * i), 3'b010, 32'h10000000 + 32'(i), a0[i]);
            end
            begin : rr_p1
                for (int j = 0; j < 4; j++) drive(1, 1'b1, 32'h40 + 32'(4 * j), 3'b010, 32'h20000000 + 32'(j), a1[j]);
            end
        join
        for (int i = 0; i < 4; i++) chk("rr_p1_follows_p0", 32'(a1[i] - a0[i]), 32'd1);
        for (int i = 0; i < 3; i++) chk("rr_p0_follows_p1", 32'(a0[i + 1] - a1[i]), 32'd1);

        // reset during the read-modify-write cycle aborts the store
        drive(0, 1'b1, 32'h8, 3'b010, 32'hCAFEBABE, acc);
        wait_resp(0, d, e, n);
        drive(0, 1'b1, 32'h8, 3'b001, 32'h1234, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_resp_valid", resp_valid, 32'h0);
        chk("abort_busy", busy, 32'h0);
        chk("abort_word2", mem[2], 32'hCAFEBABE);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h8, 3'b010, 32'h0, acc);
        wait_resp(1, d, e, n);
        chk("abort_readback", d, 32'hCAFEBABE);

        repeat (3) @(posedge clk);
        #1;
        foreach (final_words[k]) chk("mem_vs_model", mem[final_words[k]], ref_mem[final_words[k]]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester controller for the single-port, word-organised data memory behind the MEM stage. It arbitrates between the pipeline (port 0) and a DMA/debug loader (port 1), and sequences each granted access. Byte and halfword stores become a read-modify-write; loads are sign- or zero-extended to RV32I semantics. It sits between the MEM stage and the memory array; requesters stall on `req_ready`.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the memory.
- `AW`, `$clog2(DEPTH)`: width of the word address.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  request present, one bit per port.
- `req_ready[1:0]`  out  2  the request on this port is accepted this cycle.
- `req_we[1:0]`  in  2  1 = store, 0 = load.
- `req_addr0`, `req_addr1`  in  32 each  byte address.
- `req_funct3_0`, `req_funct3_1`  in  3 each  access size and sign (RV32I funct3).
- `req_wdata0`, `req_wdata1`  in  32 each  store data; right-aligned for SB/SH.
- `resp_valid[1:0]`  out  2  one-cycle completion pulse for the owning port.
- `resp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `resp_err`  out  1  the completed access was rejected; qualified by `resp_valid`.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  write when `mem_en`=1.
- `mem_addr`  out  AW  word address.
- `mem_wdata`  out  32  full merged word.
- `mem_rdata`  in  32  read data, valid the cycle after a read with `mem_en`=1, `mem_we`=0.
- `busy`  out  1  FSM is not IDLE.

## Operation
- FSM states are IDLE, LD_WAIT and RMW_WR.
- Accepts only occur in IDLE.
- **Arbitration:**
  - With one port valid, that port is granted.
  - With both valid, grant goes to the port opposite `last_grant`.
  - `last_grant` updates on every accept and resets to 1, so port 0 wins the first tie.
  - `req_ready` is 1 only for the granted port, only in IDLE.
- **Decode at accept:**
  - Word index is `addr[31:2]`; byte lane is `addr[1:0]`.
- **Error conditions:**
  - Any of the following is an error: word index ≥ DEPTH; a halfword with `addr[0]`=1; a word with `addr[1:0]`≠0; load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
  - Error response: no memory access, FSM stays IDLE, next cycle `resp_valid[p]`=1 with `resp_err`=1 and `resp_rdata`=0.
- **SW:**
  - Written in the accept cycle: `mem_en`=1, `mem_we`=1, `mem_wdata`=wdata.
  - Stays in IDLE; acknowledged next cycle.
- **SB/SH:**
  - Accept cycle issues a read and goes to RMW_WR.
  - RMW_WR merges the byte or half into `mem_rdata` at the lane, writes the word, and returns to IDLE.
  - Acknowledged next cycle.
  - The lane offset, port, wdata and funct3 are latched at accept.
- **Loads:**
  - Accept cycle issues a read and goes to LD_WAIT.
  - LD_WAIT captures `mem_rdata`, selects the byte (lane `addr[1:0]`) or half (`addr[1]`), extends it, and returns to IDLE.
  - The formatted result appears next cycle.
  - Extension: LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- **Response outputs:**
  - `resp_*` are registered and pulse for exactly one cycle.
  - `resp_rdata` and `resp_err` hold their value until the next response.
- **Reset (`rst`):**
  - State goes to IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `last_grant`=1.
  - `mem_en`, `mem_we` and `req_ready` are forced to 0 while `rst`=1.
  - A reset during RMW_WR or LD_WAIT aborts the access: no write occurs and no response is produced.

## Timing
Accept cycle is T.
- **Latency:**
  - Error: `resp_valid` at T+1.
  - SW: memory written at T; `resp_valid` at T+1.
  - Load: read at T, data at T+1, `resp_valid` at T+2.
  - SB/SH: read at T, write at T+1, `resp_valid` at T+2.
- **Back-to-back acceptance:**
  - SW and errors allow a new accept at T+1.
  - Loads and RMW stores allow a new accept at T+2; this is the same cycle as their `resp_valid`.
- **Throughput:**
  - One SW per cycle.
  - One load or sub-word store per 2 cycles.
- **Request hold:** requesters hold `req_*` stable until `req_ready`. A request that drops before acceptance is ignored.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid` and state.
  - `mem_*` are combinational from state and latched or accepted fields.
  - No combinational path from `mem_rdata` to `mem_*` except the RMW merge in RMW_WR.

## Test plan
- **Reset values:** assert `rst` 2 cycles → all outputs 0, `busy`=0. Then both ports request LW together → port 0 granted first, port 1 on the following accept.
- **SB lane merge:** memory word 3 = 0xAABBCCDD; port 0 SB addr 0xD, wdata 0x11 → read then write 0xAABB11DD; `resp_valid[0]` at T+2. A following LBU addr 0xD returns 0x00000011.
- **Load extension:** word 1 = 0x8001F0FF →
  - LB addr 0x4 = 0xFFFFFFFF
  - LH addr 0x6 = 0xFFFF8001
  - LHU addr 0x6 = 0x00008001
  - LW = 0x8001F0FF
- **Round-robin:** both ports stream SW continuously → grants alternate 0,1,0,1 on consecutive cycles, one `resp_valid` per cycle to the matching port.
- **Error cases:** LH addr 0x3, SW addr 0x1002 (DEPTH=1024), and funct3 011 each produce `resp_err`=1 at T+1 with no `mem_en`. Memory contents are unchanged.
- **Reset abort:** SH to addr 0x8, `rst` asserted in the RMW_WR cycle → no write, no `resp_valid`; word 2 retains its prior value, and the FSM is IDLE the next cycle.
